// File: rtl/audio_out_pkg.sv
// Shared types and constants for the two-source audio stream arbiter:
// FSM states, CSR map, CTRL bit positions, ID word and a saturating counter helper.
package audio_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic [2:0] CSR_CTRL     = 3'd0;
    localparam logic [2:0] CSR_STATUS   = 3'd1;
    localparam logic [2:0] CSR_PKT_CNT0 = 3'd2;
    localparam logic [2:0] CSR_PKT_CNT1 = 3'd3;
    localparam logic [2:0] CSR_DROP_CNT = 3'd4;
    localparam logic [2:0] CSR_ID       = 3'd5;

    localparam int CTRL_EN0   = 0;
    localparam int CTRL_EN1   = 1;
    localparam int CTRL_FIXED = 2;
    localparam int CTRL_CLR   = 3;

    localparam logic [31:0] ARB_ID = 32'h4155_4152;

    typedef struct packed {
        logic       fixed;
        logic [1:0] en;
    } ctrl_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker: round-robin against the last served source, or source 0 priority when fixed.
// Purely combinational, no backpressure; the caller registers the result.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       fixed,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = fixed ? 1'b0 : ~last;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/audio_stream_arb.sv
// Packet-granular 2:1 audio stream arbiter with CSR block; one registered cycle IDLE->GRANT, then
// zero-latency passthrough where m_ready backpressures only the granted source. Reads return next cycle.
module audio_stream_arb
    import audio_out_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                  d_clock,
    input  logic                  d_reset,
    input  logic [1:0]            s_data_valid,
    output logic [1:0]            s_ready,
    input  logic [1:0]            s_start_packet,
    input  logic [1:0]            s_end_packet,
    input  logic [2*DATA_W-1:0]   s_data,
    output logic                  m_data_valid,
    input  logic                  m_ready,
    output logic                  m_start_packet,
    output logic                  m_end_packet,
    output logic [DATA_W-1:0]     m_data,
    input  logic [2:0]            iCSR_ADDRESS,
    input  logic                  iCSR_READ,
    input  logic                  iCSR_WRITE,
    input  logic [31:0]           iCSR_WRITE_DATA,
    output logic [31:0]           oCSR_READ_DATA
);

    state_t      state, state_nxt;
    ctrl_t       ctrl;
    logic        last;
    logic [31:0] pkt_cnt0, pkt_cnt1, drop_cnt;
    logic [1:0]  cand, drop;
    logic [1:0]  drop_inc;
    logic        gnt_vld, gnt_idx;
    logic        sel, eop_acc;
    logic        ctrl_wr, cnt_clr;
    logic [31:0] rd_dat;
    logic        wdata_unused;

    assign sel      = (state == ST_GRANT1);
    assign cand     = ctrl.en & s_data_valid & s_start_packet;
    // Non-SOP beats offered while idle belong to no packet: accept and discard them.
    assign drop     = (state == ST_IDLE) ? (ctrl.en & s_data_valid & ~s_start_packet) : 2'b00;
    assign drop_inc = {1'b0, drop[0]} + {1'b0, drop[1]};

    assign ctrl_wr      = iCSR_WRITE && (iCSR_ADDRESS == CSR_CTRL);
    assign cnt_clr      = ctrl_wr && iCSR_WRITE_DATA[CTRL_CLR];
    assign wdata_unused = ^iCSR_WRITE_DATA[31:4];

    rr_arb2 u_rr_arb2 (
        .req     (cand),
        .fixed   (ctrl.fixed),
        .last    (last),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_nxt      = state;
        s_ready        = 2'b00;
        m_data_valid   = 1'b0;
        m_start_packet = 1'b0;
        m_end_packet   = 1'b0;
        m_data         = '0;
        eop_acc        = 1'b0;
        case (state)
            ST_IDLE: begin
                s_ready = drop;
                if (gnt_vld) begin
                    state_nxt = gnt_idx ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                // Enable is not consulted here so a packet in flight always completes.
                m_data_valid   = s_data_valid[sel];
                m_start_packet = s_start_packet[sel];
                m_end_packet   = s_end_packet[sel];
                m_data         = sel ? s_data[DATA_W +: DATA_W] : s_data[0 +: DATA_W];
                s_ready        = sel ? {m_ready, 1'b0} : {1'b0, m_ready};
                if (s_data_valid[sel] && m_ready && s_end_packet[sel]) begin
                    eop_acc   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_dat = '0;
        case (iCSR_ADDRESS)
            CSR_CTRL: begin
                rd_dat[CTRL_EN0]   = ctrl.en[0];
                rd_dat[CTRL_EN1]   = ctrl.en[1];
                rd_dat[CTRL_FIXED] = ctrl.fixed;
            end
            CSR_STATUS:   rd_dat[2:0] = {last, sel, (state != ST_IDLE)};
            CSR_PKT_CNT0: rd_dat = pkt_cnt0;
            CSR_PKT_CNT1: rd_dat = pkt_cnt1;
            CSR_DROP_CNT: rd_dat = drop_cnt;
            CSR_ID:       rd_dat = ARB_ID;
            default:      rd_dat = '0;
        endcase
    end

    always_ff @(posedge d_clock) begin
        if (d_reset) begin
            state          <= ST_IDLE;
            ctrl           <= '0;
            last           <= 1'b1;
            pkt_cnt0       <= '0;
            pkt_cnt1       <= '0;
            drop_cnt       <= '0;
            oCSR_READ_DATA <= '0;
        end else begin
            state <= state_nxt;
            if (eop_acc) begin
                last <= sel;
            end
            if (ctrl_wr) begin
                ctrl.en[0] <= iCSR_WRITE_DATA[CTRL_EN0];
                ctrl.en[1] <= iCSR_WRITE_DATA[CTRL_EN1];
                ctrl.fixed <= iCSR_WRITE_DATA[CTRL_FIXED];
            end
            // Clear has priority over any increment landing on the same edge.
            if (cnt_clr) begin
                pkt_cnt0 <= '0;
                pkt_cnt1 <= '0;
                drop_cnt <= '0;
            end else begin
                if (eop_acc && !sel) pkt_cnt0 <= pkt_cnt0 + 32'd1;
                if (eop_acc && sel)  pkt_cnt1 <= pkt_cnt1 + 32'd1;
                drop_cnt <= sat_add32(drop_cnt, drop_inc);
            end
            if (iCSR_READ) begin
                oCSR_READ_DATA <= rd_dat;
            end
        end
    end

endmodule

// File: doc/audio_stream_arb.md
AUDIO_STREAM_ARB -- requirements
Module: audio_stream_arb

Interface
REQ-001 Parameter DATA_W, default 1: stream data width, matching the AUDIO_OUT sink d_data.
REQ-002 d_clock  in  1  sole clock; all logic rising-edge.
REQ-003 d_reset  in  1  synchronous, active-high reset.
REQ-004 s_data_valid  in  2  per-source beat valid, bit n = source n.
REQ-005 s_ready  out  2  per-source beat accept.
REQ-006 s_start_packet  in  2  per-source first beat of packet.
REQ-007 s_end_packet  in  2  per-source last beat of packet.
REQ-008 s_data  in  2*DATA_W  source n data at [n*DATA_W +: DATA_W].
REQ-009 m_data_valid  out  1  beat valid toward AUDIO_OUT d_data_valid.
REQ-010 m_ready  in  1  from AUDIO_OUT d_ready.
REQ-011 m_start_packet  out  1  to d_start_packet.
REQ-012 m_end_packet  out  1  to d_end_packet.
REQ-013 m_data  out  DATA_W  to d_data.
REQ-014 iCSR_ADDRESS  in  3  CSR word address.
REQ-015 iCSR_READ / iCSR_WRITE  in  1 each  CSR strobes.
REQ-016 iCSR_WRITE_DATA  in  32  write data; oCSR_READ_DATA  out  32  registered read data.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, GRANT0, GRANT1.
REQ-018 Transfers are packet-granular: a grant SHALL be held from the SOP beat through the accepted EOP beat, inclusive.
REQ-019 In IDLE, candidate n = CTRL.en[n] & s_data_valid[n] & s_start_packet[n]; the winner is registered, so IDLE->GRANTn takes one cycle, and the first beat can transfer no earlier than the cycle after entry.
REQ-020 With CTRL.fixed=0 and both candidates present, the block SHALL grant the source not equal to LAST; with CTRL.fixed=1, source 0 SHALL always win; a single candidate SHALL win in either mode.
REQ-021 In GRANTn the passthrough SHALL be combinational: m_* = s_*[n], s_ready[n] = m_ready, s_ready[other] = 0.
REQ-022 On an accepted beat with s_end_packet[n]=1 in GRANTn, the block SHALL return to IDLE, set LAST=n, and increment PKT_CNTn (32-bit, wraps 0xFFFFFFFF->0).
REQ-023 In IDLE, m_data_valid=0; an enabled source presenting valid without SOP SHALL get s_ready=1, its beat SHALL be discarded, and DROP_CNT SHALL increment (32-bit, saturating at 0xFFFFFFFF).
REQ-024 A disabled source SHALL see s_ready=0 in IDLE; clearing CTRL.en[n] during GRANTn SHALL NOT cut the packet, which completes normally.
REQ-025 An SOP arriving mid-packet in GRANTn SHALL pass through unchanged and SHALL NOT alter the grant.
REQ-026 CSR map: 0 CTRL rw [0] en0, [1] en1, [2] fixed, [3] clr (write-1, self-clearing, reads 0); 1 STATUS ro [0] busy, [1] grant idx, [2] LAST; 2 PKT_CNT0 ro; 3 PKT_CNT1 ro; 4 DROP_CNT ro; 5 ID ro = 0x4155_4152; 6-7 read 0.
REQ-027 Read data SHALL be registered and valid the cycle after iCSR_READ; it SHALL hold otherwise; writes to read-only addresses SHALL be ignored.
REQ-028 CTRL writes SHALL take effect the following cycle; when a clear and an increment coincide, the clear SHALL win (counter = 0).

Reset
REQ-029 When d_reset=1 the block SHALL enter IDLE, with CTRL=0, LAST=1 (source 0 served first), all counters=0, oCSR_READ_DATA=0, s_ready=0, m_data_valid=0.
REQ-030 Reset asserted mid-packet SHALL abort the grant immediately; the next cycle's outputs SHALL be the reset values.

Structure
REQ-031 Package audio_out_pkg SHALL hold the FSM state enum, CSR address constants, CTRL bit indices and the ID constant.
REQ-032 The two-way round-robin/fixed picker SHALL be a sub-module named rr_arb2; the CSR file and counters stay in the top level.

Verification
REQ-033 Reset, then read ID at address 5 -> 0x41554152 one cycle after iCSR_READ; CTRL reads 0.
REQ-034 CTRL=0x3 and both sources offer 4-beat packets continuously -> grants alternate 0,1,0,1; after 4 packets PKT_CNT0=2, PKT_CNT1=2.
REQ-035 CTRL=0x7 with both sources always pending -> only source 0 granted; PKT_CNT1=0.
REQ-036 m_ready toggling 1/0 during a 6-beat packet -> all 6 beats delivered in order, no loss, and grant released only after the EOP is accepted.
REQ-037 Source 1 sends 3 non-SOP beats while IDLE with en1=1 -> DROP_CNT=3 and m_data_valid stays 0; then write CTRL=0x8 on the same cycle as a drop -> DROP_CNT=0.
REQ-038 Assert d_reset on beat 2 of a packet -> the next cycle shows s_ready=0, m_data_valid=0 and STATUS.busy=0.
